seq_pattern_tx: RTL
===================

# seq_pattern_tx

Serial pattern transmitter that drives single-bit streams for the team's serial sequence detectors. A parallel pattern of programmable length and repeat count is accepted over a valid/ready load port and shifted out MSB-first, one bit per clock, with a qualifying valid strobe. It is the stimulus-side counterpart of the detector blocks and is used both as a traffic source on chip and as a bench driver.

## Interface
- PAT_W, 8: maximum pattern length in bits.
- LEN_W, 4: width of the `load_len` field; must satisfy 2^LEN_W > PAT_W.
- CNT_W, 4: width of the `load_rep` field.
- IDLE_BIT, 1'b0: level driven on `x` when no pattern bit is being sent.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  load request.
- load_ready  out  1  block can accept a load.
- load_pat  in  PAT_W  pattern; the low `len` bits are sent.
- load_len  in  LEN_W  pattern length in bits.
- load_rep  in  CNT_W  extra repetitions; total sends = load_rep+1.
- abort  in  1  cancels the transmission in progress.
- x  out  1  serial data bit.
- x_valid  out  1  `x` carries a pattern bit this cycle.
- busy  out  1  a transmission is in progress.
- done  out  1  one-cycle pulse at normal completion.

## Operation
- The FSM has four states: IDLE, SEND, GAP and DONE. GAP is present only with the macro.
- All outputs are registered. Reset values: x=IDLE_BIT, x_valid=0, busy=0, done=0, load_ready=1, state IDLE.
- IDLE:
  - load_ready=1.
  - On load_valid&&load_ready, the block latches pat, len and rep, clears the bit index and repeat counter, and goes to SEND.
- Length rule: len = load_len. If load_len==0 or load_len>PAT_W, len = PAT_W.
- SEND:
  - Drives x = pat[len-1-idx] with x_valid=1, busy=1.
  - idx increments each cycle.
  - After bit idx==len-1:
    - If the repeat counter < rep: counter increments, idx clears, next state is GAP with the macro or SEND without it.
    - Otherwise: next state is DONE.
- GAP: one cycle with x=IDLE_BIT, x_valid=0, busy=1. Then SEND.
- DONE: one cycle with done=1, busy=0, x_valid=0, x=IDLE_BIT, load_ready=1. A load may be accepted in this cycle.
- abort:
  - If sampled high in SEND or GAP: next cycle is IDLE with reset output values. done is not pulsed.
  - Ignored in IDLE and DONE.
- load_valid while load_ready=0 is ignored; no queueing.
- rst has priority over abort and loads. Mid-transmission, the outputs return to their reset values at the next edge.
- Counter widths: idx is LEN_W bits and the repeat counter is CNT_W bits. Neither can overflow given the rules above.

## Timing
- Load accepted at edge N → first bit is valid in cycle N+1.
- Each bit is held for exactly one cycle.
- Transmission length in cycles:
  - Without the macro: len·(rep+1).
  - With the macro: len·(rep+1)+rep.
- The last bit is in cycle L. done=1 and load_ready=1 in cycle L+1.
- Back-to-back loads: a load accepted in the DONE cycle puts its first bit in L+2. The minimum inter-transmission gap is one idle cycle.
- load_ready falls in the cycle after acceptance and rises in the DONE cycle, or the cycle after an abort.

## Configuration
- SEQ_PATTERN_TX_GAP_EN:
  - Defined: one GAP cycle (x=IDLE_BIT, x_valid=0) is inserted between consecutive repetitions.
  - Undefined: repetitions are sent back-to-back, GAP is not generated, and x_valid stays high for the whole transmission.

## Test plan
- Reset: hold rst 2 cycles mid-stream → next cycle x=IDLE_BIT, x_valid=0, busy=0, done=0, load_ready=1.
- Single send: pat=8'h0A, len=4, rep=0 → x=1,0,1,0 in cycles N+1..N+4 with x_valid=1; done=1 in N+5; load_ready=1 in N+5.
- Repeat: pat=3'b101, len=3, rep=2:
  - Without the macro: 9 valid cycles 101101101.
  - With the macro: 11 cycles 101·g·101·g·101, where g has x_valid=0.
  - done follows the last bit in both cases.
- Length clamp: load_len=0 and load_len=15 with pat=8'hC3 → both send 8 bits 1,1,0,0,0,0,1,1.
- Abort: pulse abort during the 2nd bit of an 8-bit send → next cycle x_valid=0, busy=0, load_ready=1; done never pulses.
- Load while busy: assert load_valid with pat=8'hFF during a send → ignored; the original stream completes unchanged; a load in the DONE cycle is accepted.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a loaded pattern out MSB-first, one bit per clock.
// Define SEQ_PATTERN_TX_GAP_EN to insert one idle GAP cycle between repetitions.
module seq_pattern_tx #(
  parameter int   PAT_W    = 8,
  parameter int   LEN_W    = 4,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] load_pat,
  input  logic [LEN_W-1:0] load_len,
  input  logic [CNT_W-1:0] load_rep,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  // Handshake: a load transfers on any rising edge where load_valid && load_ready;
  // load_ready is a registered output, high only in IDLE and DONE.
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  state_t           state;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  logic [CNT_W-1:0] rep;
  logic [CNT_W-1:0] cnt;

  logic [LEN_W-1:0] load_len_eff;
  logic [LEN_W-1:0] idx_next;
  logic             accept;
  logic             last_bit;

  // Shift instead of a variable bit-select so the position width need not match PAT_W.
  function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] pos);
    logic [PAT_W-1:0] s;
    s = p >> pos;
    return s[0];
  endfunction

  always_comb begin
    load_len_eff = load_len;
    if (load_len == '0 || load_len > PAT_LEN) load_len_eff = PAT_LEN;
  end

  assign accept   = load_valid && load_ready;
  assign idx_next = idx + ONE_L;
  assign last_bit = (idx == len - ONE_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x          <= IDLE_BIT;
      x_valid    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
      pat        <= '0;
      len        <= '0;
      idx        <= '0;
      rep        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state      <= IDLE;
          x          <= IDLE_BIT;
          x_valid    <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          load_ready <= 1'b1;
          if (accept) begin
            state      <= SEND;
            pat        <= load_pat;
            len        <= load_len_eff;
            rep        <= load_rep;
            idx        <= '0;
            cnt        <= '0;
            x          <= bit_at(load_pat, load_len_eff - ONE_L);
            x_valid    <= 1'b1;
            busy       <= 1'b1;
            load_ready <= 1'b0;
          end
        end
        SEND: begin
          if (abort) begin
            state      <= IDLE;
            x          <= IDLE_BIT;
            x_valid    <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else if (last_bit) begin
            if (cnt < rep) begin
              cnt <= cnt + CNT_W'(1);
              idx <= '0;
`ifdef SEQ_PATTERN_TX_GAP_EN
              state   <= GAP;
              x       <= IDLE_BIT;
              x_valid <= 1'b0;
`else
              x       <= bit_at(pat, len - ONE_L);
`endif
            end else begin
              state      <= DONE;
              x          <= IDLE_BIT;
              x_valid    <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              load_ready <= 1'b1;
            end
          end else begin
            idx <= idx_next;
            x   <= bit_at(pat, len - ONE_L - idx_next);
          end
        end
        GAP: begin
          if (abort) begin
            state      <= IDLE;
            x          <= IDLE_BIT;
            x_valid    <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else begin
            state   <= SEND;
            x       <= bit_at(pat, len - ONE_L);
            x_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
